// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default baud divisor, line idle level.
// Parity-capable state encoding is always present; the PARITY state is used only under UART_TX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } uart_state_e;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;
  localparam logic        LINE_IDLE            = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, flags the last cycle of each period.
// Shared between the UART transmitter and receiver.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_bit_end_c
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] r_cnt;

  assign o_bit_end_c = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst || i_clr || o_bit_end_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: latches a byte on request and sends it LSB-first as 8N1
// (8E1 when UART_TX_PARITY_EN is defined), pulsing t_done after the stop bit.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 transmit,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx,
  output logic                 busy,
  output logic                 t_done
);

  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  uart_state_e          r_state;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_t_done;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
`endif

  logic w_bit_end;
  logic w_baud_clr;

  // Counter held at zero outside the frame so START always gets a full bit period.
  assign w_baud_clr = (r_state == ST_IDLE) || (r_state == ST_DONE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_baud_clr),
    .o_bit_end_c(w_bit_end)
  );

  // Each transition loads tx with the level of the state being entered, keeping tx registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_tx      <= LINE_IDLE;
      r_busy    <= 1'b0;
      r_t_done  <= 1'b0;
      r_bit_idx <= '0;
      r_shift   <= '0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_t_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_tx   <= LINE_IDLE;
          r_busy <= 1'b0;
          if (transmit) begin
            r_shift <= data_in;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^data_in;
`endif
            r_state <= ST_START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_state   <= ST_DATA;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_shift <= r_shift >> 1;
            if (r_bit_idx == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              r_state <= ST_PARITY;
              r_tx    <= r_parity;
`else
              r_state <= ST_STOP;
              r_tx    <= LINE_IDLE;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + IDX_W'(1);
              r_tx      <= r_shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (w_bit_end) begin
            r_state <= ST_STOP;
            r_tx    <= LINE_IDLE;
          end
        end
`endif
        ST_STOP: begin
          if (w_bit_end) begin
            r_state  <= ST_DONE;
            r_busy   <= 1'b0;
            r_t_done <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_tx    <= LINE_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= LINE_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign tx     = r_tx;
  assign busy   = r_busy;
  assign t_done = r_t_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer at CLKS_PER_BIT=4; parity frame layout
// follows UART_TX_PARITY_EN when the bench is built with that macro.
module tb_uart_tx_serializer;

  localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned PAR = 1;
`else
  localparam int unsigned PAR = 0;
`endif
  localparam int FRAME_BITS = 10 + int'(PAR);
  localparam int DONE_CYC   = FRAME_BITS * int'(CPB) + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       transmit;
  logic [7:0] data_in;
  logic       tx;
  logic       busy;
  logic       t_done;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .transmit(transmit),
    .data_in (data_in),
    .tx      (tx),
    .busy    (busy),
    .t_done  (t_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line level k cycles after the accepting edge: start, 8 data LSB-first, [parity], stop, idle.
  function automatic logic exp_tx(input int k, input logic [7:0] d);
    int b;
    if (k < 1) return 1'b1;
    b = (k - 1) / int'(CPB);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (PAR == 1 && b == 9) return ^d;
    return 1'b1;
  endfunction

  // mode 0: one-cycle pulse; 1: held, debouncer clears after t_done; 2: data_in changed mid-frame;
  // 3: retrigger while busy; 4: held with no clear (immediate restart)
  task automatic run_frame(input string tag, input logic [7:0] d, input int mode);
    logic seen_done;
    int   lows;
    seen_done = 1'b0;
    data_in   = d;
    transmit  = 1'b1;
    tick();
    if (mode == 0 || mode == 2 || mode == 3) transmit = 1'b0;
    for (int k = 1; k <= DONE_CYC + 1; k++) begin
      chk({tag, "_tx"},     32'(tx),     32'(exp_tx(k, d)));
      chk({tag, "_busy"},   32'(busy),   32'(k < DONE_CYC));
      chk({tag, "_t_done"}, 32'(t_done), 32'(k == DONE_CYC));
      seen_done = t_done;
      if (mode == 2 && k == 12) data_in = ~d;
      if (mode == 3 && k == 15) begin transmit = 1'b1; data_in = ~d; end
      if (mode == 3 && k == 16) transmit = 1'b0;
      tick();
      if (mode == 1 && seen_done) transmit = 1'b0;
    end
    if (mode == 1) begin
      lows = 0;
      for (int k = 0; k < 10 * int'(CPB); k++) begin
        if (tx == 1'b0 || busy == 1'b1) lows++;
        tick();
      end
      chk({tag, "_no_restart"}, 32'(lows), 32'd0);
    end
    if (mode == 4) begin
      chk({tag, "_restart_tx"},   32'(tx),   32'd0);
      chk({tag, "_restart_busy"}, 32'(busy), 32'd1);
      transmit = 1'b0;
      repeat (DONE_CYC + int'(CPB)) tick();
      chk({tag, "_settled_busy"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int lows;
    int dones;
    rst      = 1'b1;
    transmit = 1'b0;
    data_in  = 8'h00;
    tick();
    tick();
    chk("rst_tx",     32'(tx),     32'd1);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_t_done", 32'(t_done), 32'd0);
    rst = 1'b0;
    tick();

    run_frame("a5",      8'hA5, 0);
    run_frame("held55",  8'h55, 1);
    run_frame("ff_chg",  8'hFF, 2);
    run_frame("retrig",  8'h3C, 3);

    // Abort during data bit 3 of an all-zero frame
    data_in  = 8'h00;
    transmit = 1'b1;
    tick();
    transmit = 1'b0;
    repeat (17) tick();
    chk("abort_pre_tx", 32'(tx), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_tx",     32'(tx),     32'd1);
    chk("abort_busy",   32'(busy),   32'd0);
    chk("abort_t_done", 32'(t_done), 32'd0);
    lows  = 0;
    dones = 0;
    for (int k = 0; k < 60; k++) begin
      if (tx == 1'b0) lows++;
      if (t_done == 1'b1) dones++;
      tick();
    end
    chk("abort_quiet_tx",     32'(lows),  32'd0);
    chk("abort_quiet_t_done", 32'(dones), 32'd0);

    run_frame("post_abort", 8'h81, 0);
    run_frame("b2b",        8'hC3, 4);
    run_frame("par07",      8'h07, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
